cpu_mem_ctrl: RTL and testbench
===============================

Name: cpu_mem_ctrl

Overview:
- Byte-addressed CPU memory controller between the CPU access units and the word-organised dual-read/single-write memory.
- One write port and two read ports: port 0 serves instruction fetch, port 1 serves data loads.
- Translates 16-bit byte addresses to 15-bit word addresses, generates byte-lane write enables, and aligns/zero-extends byte reads.
- Flags misaligned accesses.

Parameters:
- DATA_W, 16, data width in bits (two byte lanes); fixed, not to be changed.
- ADDR_W, 16, CPU byte-address width; memory word address is ADDR_W-1 bits.
- NRD, 2, number of read ports; fixed.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_size  in  1  1 = word, 0 = byte.
- wr_addr  in  16  write byte address.
- wr_data  in  16  write data; byte writes use bits [7:0].
- rd_en[0:1]  in  1 each  read request per port.
- rd_size[0:1]  in  1 each  1 = word, 0 = byte.
- rd_addr[0:1]  in  16 each  read byte address.
- mem_rd_done[0:1]  in  1 each  memory read-complete strobe.
- mem_rd_data[0:1]  in  16 each  memory read word.
- mem_rd_en[0:1]  out  1 each  memory read enable.
- mem_rd_addr[0:1]  out  15 each  memory read word address.
- mem_wr_en  out  2  byte-lane write enables; bit1 = high byte, bit0 = low byte.
- mem_wr_addr  out  15  memory write word address.
- mem_wr_data  out  16  lane-positioned write data.
- invalid_wr_addr  out  1  misaligned write request.
- invalid_rd_addr[0:1]  out  1 each  misaligned read request.
- rd_done[0:1]  out  1 each  read result valid.
- rd_data[0:1]  out  16 each  formatted read result.

Behaviour:
- Address split:
  - word address = addr[15:1]; byte select = addr[0].
  - Byte address 0 is low byte (little-endian).
- Misalignment:
  - A request with size = 1 and addr[0] = 1 is invalid.
  - invalid_* is combinational, asserted only while the matching en is high.
  - Invalid requests are never forwarded: mem_rd_en = 0 / mem_wr_en = 00 for that port.
  - Byte accesses are always valid.
- Write path, all combinational:
  - word: mem_wr_en = 11, mem_wr_data = wr_data.
  - byte, addr[0] = 0: mem_wr_en = 01, data = {8'h00, wr_data[7:0]}.
  - byte, addr[0] = 1: mem_wr_en = 10, data = {wr_data[7:0], 8'h00}.
  - mem_wr_addr = wr_addr[15:1].
  - wr_en = 0 → mem_wr_en = 00.
- Read request path, combinational per port:
  - mem_rd_en = rd_en & valid; mem_rd_addr = rd_addr[15:1].
  - On every rising clk edge where mem_rd_en is asserted, latch size and addr[0] into a per-port pending register.
- Read response path, per port:
  - rd_done = mem_rd_done, passed through in the same cycle.
  - rd_data formatted from the latched info:
    - word: mem_rd_data.
    - byte offset 0: {8'h00, mem_rd_data[7:0]}.
    - byte offset 1: {8'h00, mem_rd_data[15:8]}.
  - While rd_done = 0, rd_data = 0.
- Latency:
  - The controller adds zero cycles.
  - With a synchronous memory, rd_done arrives one cycle after the accepted rd_en.
  - Back-to-back reads each cycle are supported; the pending register updates on every accepted request.
- Concurrency:
  - The two read ports and the write port are fully independent and operate in the same cycle.
  - Same-word write and read in one cycle: no forwarding; ordering is the memory's (read returns old data).
- Reset (asynchronous, active high):
  - Clears pending registers to word/offset 0.
  - While reset is high, mem_rd_en, mem_wr_en, rd_done and invalid_* are forced to 0, and rd_data to 0.
  - A read in flight when reset asserts is dropped; no rd_done is produced for it.

Decomposition:
- Shared package: access-size constants SIZE_BYTE = 1'b0, SIZE_WORD = 1'b1; DATA_W / ADDR_W constants; lane-enable constants LANE_LO = 2'b01, LANE_HI = 2'b10, LANE_BOTH = 2'b11.
- One sub-module: cpu_mem_rd_port.
  - Contents: alignment check, request gating, pending register, byte select/zero-extend.
  - Instantiated NRD times; the write logic stays in the top.

Test Plan:
- Word write wr_addr = 0x0010, wr_data = 0xBEEF, size = 1 → mem_wr_en = 11, mem_wr_addr = 0x0008, mem_wr_data = 0xBEEF, invalid_wr_addr = 0.
- Byte write wr_addr = 0x0011, wr_data = 0x12A5, size = 0 → mem_wr_en = 10, mem_wr_data = 0xA500. Then word read port 1 at 0x0010 → rd_data[1] = 0xA5EF one cycle later with rd_done[1] = 1.
- Byte read port 1 at 0x0011 then 0x0010 on consecutive cycles → rd_data[1] = 0x00A5 then 0x00EF, rd_done high both cycles.
- Misaligned word read port 0 at 0x0003 → invalid_rd_addr[0] = 1, mem_rd_en[0] = 0, no rd_done[0]. Misaligned word write at 0x0005 → invalid_wr_addr = 1, mem_wr_en = 00.
- Instruction-fetch loop: port 0 word reads at 0x0000, 0x0002, 0x0004 on alternate cycles, simultaneous with port 1 byte reads → each port returns its own correct data with no cross-port corruption.
- Assert reset while a read is pending → rd_done = 0, all enables 0 immediately. After deassertion, a fresh word read at 0x0000 returns correctly.

Source files
------------

// File: rtl/cpu_mem_ctrl_pkg.sv
// Shared constants and types for the byte-addressed CPU memory controller.
package cpu_mem_ctrl_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int NRD    = 2;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam logic [1:0] LANE_LO   = 2'b01;
    localparam logic [1:0] LANE_HI   = 2'b10;
    localparam logic [1:0] LANE_BOTH = 2'b11;

    // Access info remembered between an accepted read and its returning data.
    typedef struct packed {
        logic size;
        logic off;
    } rd_pend_t;

    function automatic logic misaligned(input logic size, input logic off);
        return (size == SIZE_WORD) && off;
    endfunction
endpackage

// File: rtl/cpu_mem_ctrl_rd_port.sv
// One read port: alignment check, request gating, pending access info and
// byte select / zero-extend of the returning memory word.
module cpu_mem_rd_port
    import cpu_mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en_i,
    input  logic              rd_size_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              mem_rd_done_i,
    input  logic [DATA_W-1:0] mem_rd_data_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-2:0] mem_rd_addr_o,
    output logic              invalid_o,
    output logic              rd_done_o,
    output logic [DATA_W-1:0] rd_data_o
);
    localparam int HALF = DATA_W / 2;

    rd_pend_t pend_q, pend_d;
    logic     bad;

    always_comb begin
        bad           = rd_en_i && misaligned(rd_size_i, rd_addr_i[0]);
        invalid_o     = bad && !reset;
        mem_rd_en_o   = rd_en_i && !bad && !reset;
        mem_rd_addr_o = rd_addr_i[ADDR_W-1:1];
        pend_d        = pend_q;
        if (mem_rd_en_o) pend_d = '{size: rd_size_i, off: rd_addr_i[0]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pend_q <= '{size: SIZE_WORD, off: 1'b0};
        else       pend_q <= pend_d;
    end

    // Response formatting uses the info latched with the request, not the live inputs.
    always_comb begin
        rd_done_o = mem_rd_done_i && !reset;
        rd_data_o = '0;
        if (rd_done_o) begin
            if (pend_q.size == SIZE_WORD) rd_data_o = mem_rd_data_i;
            else if (pend_q.off)          rd_data_o = {{HALF{1'b0}}, mem_rd_data_i[DATA_W-1:HALF]};
            else                          rd_data_o = {{HALF{1'b0}}, mem_rd_data_i[HALF-1:0]};
        end
    end
endmodule

// File: rtl/cpu_mem_ctrl.sv
// Byte-addressed controller in front of a 2-read/1-write word memory:
// write lane generation here, per-port read handling in cpu_mem_rd_port.
module cpu_mem_ctrl
    import cpu_mem_ctrl_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic                          wr_size,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic [NRD-1:0]                rd_en,
    input  logic [NRD-1:0]                rd_size,
    input  logic [NRD-1:0][ADDR_W-1:0]    rd_addr,
    input  logic [NRD-1:0]                mem_rd_done,
    input  logic [NRD-1:0][DATA_W-1:0]    mem_rd_data,
    output logic [NRD-1:0]                mem_rd_en,
    output logic [NRD-1:0][ADDR_W-2:0]    mem_rd_addr,
    output logic [1:0]                    mem_wr_en,
    output logic [ADDR_W-2:0]             mem_wr_addr,
    output logic [DATA_W-1:0]             mem_wr_data,
    output logic                          invalid_wr_addr,
    output logic [NRD-1:0]                invalid_rd_addr,
    output logic [NRD-1:0]                rd_done,
    output logic [NRD-1:0][DATA_W-1:0]    rd_data
);
    localparam int HALF = DATA_W / 2;

    logic wr_bad;

    always_comb begin
        wr_bad          = wr_en && misaligned(wr_size, wr_addr[0]);
        invalid_wr_addr = wr_bad && !reset;
        mem_wr_addr     = wr_addr[ADDR_W-1:1];
        mem_wr_data     = wr_data;
        mem_wr_en       = 2'b00;
        if (wr_size == SIZE_BYTE) begin
            mem_wr_data = wr_addr[0] ? {wr_data[HALF-1:0], {HALF{1'b0}}}
                                     : {{HALF{1'b0}}, wr_data[HALF-1:0]};
        end
        if (wr_en && !wr_bad && !reset) begin
            if (wr_size == SIZE_WORD) mem_wr_en = LANE_BOTH;
            else                      mem_wr_en = wr_addr[0] ? LANE_HI : LANE_LO;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        cpu_mem_rd_port u_port (
            .clk           (clk),
            .reset         (reset),
            .rd_en_i       (rd_en[p]),
            .rd_size_i     (rd_size[p]),
            .rd_addr_i     (rd_addr[p]),
            .mem_rd_done_i (mem_rd_done[p]),
            .mem_rd_data_i (mem_rd_data[p]),
            .mem_rd_en_o   (mem_rd_en[p]),
            .mem_rd_addr_o (mem_rd_addr[p]),
            .invalid_o     (invalid_rd_addr[p]),
            .rd_done_o     (rd_done[p]),
            .rd_data_o     (rd_data[p])
        );
    end
endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// Bench for cpu_mem_ctrl: synchronous word memory on the memory side, byte-array
// reference model of the CPU-visible memory, directed steps then random traffic.
module tb_cpu_mem_ctrl;
    logic              clk;
    logic              reset;
    logic              wr_en, wr_size;
    logic [15:0]       wr_addr, wr_data;
    logic [1:0]        rd_en, rd_size;
    logic [1:0][15:0]  rd_addr;
    logic [1:0]        mrd_done;
    logic [1:0][15:0]  mrd_data;
    logic [1:0]        mem_rd_en;
    logic [1:0][14:0]  mem_rd_addr;
    logic [1:0]        mem_wr_en;
    logic [14:0]       mem_wr_addr;
    logic [15:0]       mem_wr_data;
    logic              invalid_wr_addr;
    logic [1:0]        invalid_rd_addr;
    logic [1:0]        rd_done;
    logic [1:0][15:0]  rd_data;

    logic [15:0] wmem    [0:32767];
    logic [7:0]  ref_mem [0:65535];
    logic [1:0]  exp_done;
    logic [15:0] exp_data [2];
    int total, bad;

    cpu_mem_ctrl dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_size(wr_size), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_size(rd_size), .rd_addr(rd_addr),
        .mem_rd_done(mrd_done), .mem_rd_data(mrd_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .invalid_wr_addr(invalid_wr_addr), .invalid_rd_addr(invalid_rd_addr),
        .rd_done(rd_done), .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: read returns the pre-write contents; junk data when idle.
    always @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            mrd_done[p] <= mem_rd_en[p];
            mrd_data[p] <= mem_rd_en[p] ? wmem[mem_rd_addr[p]] : 16'($urandom);
        end
        if (mem_wr_en[0]) wmem[mem_wr_addr][7:0]  <= mem_wr_data[7:0];
        if (mem_wr_en[1]) wmem[mem_wr_addr][15:8] <= mem_wr_data[15:8];
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic we, input logic ws, input logic [15:0] wa, input logic [15:0] wd,
                        input logic [1:0] re, input logic [1:0] rs,
                        input logic [15:0] ra0, input logic [15:0] ra1);
        logic [15:0] ra [2];
        logic [15:0] b1, wexp;
        logic [1:0]  lanes;
        logic        mis;
        ra[0] = ra0;
        ra[1] = ra1;
        @(posedge clk); #1;
        for (int p = 0; p < 2; p++) begin
            chk("rd_done", 16'(rd_done[p]), 16'(exp_done[p]));
            chk("rd_data", rd_data[p], exp_done[p] ? exp_data[p] : 16'h0000);
        end
        wr_en = we; wr_size = ws; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_size = rs; rd_addr[0] = ra0; rd_addr[1] = ra1;
        #1;
        for (int p = 0; p < 2; p++) begin
            mis = re[p] && rs[p] && ra[p][0];
            chk("invalid_rd", 16'(invalid_rd_addr[p]), 16'(mis));
            chk("mem_rd_en", 16'(mem_rd_en[p]), 16'(re[p] && !mis));
            chk("mem_rd_addr", 16'(mem_rd_addr[p]), ra[p] >> 1);
            exp_done[p] = re[p] && !mis;
            b1 = ra[p] + 16'd1;
            exp_data[p] = rs[p] ? {ref_mem[b1], ref_mem[ra[p]]} : {8'h00, ref_mem[ra[p]]};
        end
        mis   = we && ws && wa[0];
        lanes = 2'b00;
        wexp  = 16'h0000;
        chk("invalid_wr", 16'(invalid_wr_addr), 16'(mis));
        if (we && !mis) begin
            ref_mem[wa] = wd[7:0];
            lanes[wa[0]] = 1'b1;
            wexp[int'(wa[0])*8 +: 8] = wd[7:0];
            if (ws) begin
                b1 = wa + 16'd1;
                ref_mem[b1] = wd[15:8];
                lanes[b1[0]] = 1'b1;
                wexp[int'(b1[0])*8 +: 8] = wd[15:8];
            end
        end
        chk("mem_wr_en", 16'(mem_wr_en), 16'(lanes));
        if (lanes != 2'b00) begin
            chk("mem_wr_addr", 16'(mem_wr_addr), wa >> 1);
            chk("mem_wr_data", mem_wr_data, wexp);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 2'b00, 16'h0, 16'h0);
    endtask

    initial begin
        logic [15:0] w;
        total = 0; bad = 0;
        exp_done = 2'b00;
        mrd_done = 2'b00;
        mrd_data = '0;
        for (int i = 0; i < 32768; i++) begin
            w = 16'($urandom);
            wmem[i] = w;
            ref_mem[2*i]   = w[7:0];
            ref_mem[2*i+1] = w[15:8];
        end

        // Reset state with live requests on every port.
        reset = 1'b1;
        wr_en = 1'b1; wr_size = 1'b1; wr_addr = 16'h0005; wr_data = 16'h1234;
        rd_en = 2'b11; rd_size = 2'b11; rd_addr[0] = 16'h0003; rd_addr[1] = 16'h0010;
        #2;
        chk("rst_mem_rd_en", 16'(mem_rd_en), 16'h0);
        chk("rst_mem_wr_en", 16'(mem_wr_en), 16'h0);
        chk("rst_inv_rd", 16'(invalid_rd_addr), 16'h0);
        chk("rst_inv_wr", 16'(invalid_wr_addr), 16'h0);
        chk("rst_rd_done", 16'(rd_done), 16'h0);
        #10;
        reset = 1'b0;
        wr_en = 1'b0; rd_en = 2'b00;

        step(1'b1, 1'b1, 16'h0010, 16'hBEEF, 2'b00, 2'b00, 16'h0, 16'h0);
        chk("plan_wr_word_en", 16'(mem_wr_en), 16'h0003);
        chk("plan_wr_word_addr", 16'(mem_wr_addr), 16'h0008);
        chk("plan_wr_word_data", mem_wr_data, 16'hBEEF);
        step(1'b1, 1'b0, 16'h0011, 16'h12A5, 2'b00, 2'b00, 16'h0, 16'h0);
        chk("plan_wr_byte_en", 16'(mem_wr_en), 16'h0002);
        chk("plan_wr_byte_data", mem_wr_data, 16'hA500);
        step(1'b0, 1'b0, 16'h0, 16'h0, 2'b10, 2'b10, 16'h0, 16'h0010);
        step(1'b0, 1'b0, 16'h0, 16'h0, 2'b10, 2'b00, 16'h0, 16'h0011);
        chk("plan_rd_word", rd_data[1], 16'hA5EF);
        chk("plan_rd_word_done", 16'(rd_done[1]), 16'h1);
        step(1'b0, 1'b0, 16'h0, 16'h0, 2'b10, 2'b00, 16'h0, 16'h0010);
        chk("plan_rd_byte_hi", rd_data[1], 16'h00A5);
        idle();
        chk("plan_rd_byte_lo", rd_data[1], 16'h00EF);

        step(1'b1, 1'b1, 16'h0005, 16'h5555, 2'b01, 2'b01, 16'h0003, 16'h0);
        chk("plan_inv_rd", 16'(invalid_rd_addr[0]), 16'h1);
        chk("plan_inv_wr", 16'(invalid_wr_addr), 16'h1);
        chk("plan_inv_wr_en", 16'(mem_wr_en), 16'h0);
        idle();

        // Fetch loop on port 0 every other cycle alongside byte loads on port 1.
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b0, 16'h0, 16'h0, (i % 2 == 0) ? 2'b11 : 2'b10, 2'b01,
                 16'(i / 2 * 2), 16'(16'h0010 + i));
        idle();

        // Reset while reads are in flight on both ports.
        step(1'b0, 1'b0, 16'h0, 16'h0, 2'b11, 2'b01, 16'h0000, 16'h0011);
        @(posedge clk); #1;
        reset = 1'b1;
        wr_en = 1'b1; wr_size = 1'b1; wr_addr = 16'h0020; wr_data = 16'hCAFE;
        #1;
        chk("midrst_rd_done", 16'(rd_done), 16'h0);
        chk("midrst_rd_data0", rd_data[0], 16'h0);
        chk("midrst_rd_data1", rd_data[1], 16'h0);
        chk("midrst_mem_rd_en", 16'(mem_rd_en), 16'h0);
        chk("midrst_mem_wr_en", 16'(mem_wr_en), 16'h0);
        @(posedge clk); #1;
        chk("midrst_rd_done2", 16'(rd_done), 16'h0);
        reset = 1'b0;
        wr_en = 1'b0; rd_en = 2'b00;
        exp_done = 2'b00;
        step(1'b0, 1'b0, 16'h0, 16'h0, 2'b01, 2'b01, 16'h0000, 16'h0);
        idle();

        for (int i = 0; i < 400; i++)
            step(1'($urandom), 1'($urandom), 16'($urandom_range(0, 63)), 16'($urandom),
                 2'($urandom), 2'($urandom),
                 16'($urandom_range(0, 63)), 16'($urandom_range(0, 63)));
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
